// File: rtl/sr_ctrl_pkg.sv
// Shared types and helpers for the SR-latch drive controller.
// Holds the FSM state encoding and the counter width function.
package sr_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // One width serves both the debounce and strobe counters. Each counter only
    // needs to reach its parameter minus one, so clog2 of the larger one suffices.
    function automatic int cnt_width(input int db_cycles, input int strobe_cycles);
        int m;
        m = (db_cycles > strobe_cycles) ? db_cycles : strobe_cycles;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/sr_drive_ctrl_if.sv
// Button inputs and latch-drive outputs of sr_drive_ctrl, bundled as one port.
// The master side presses buttons, and the slave side drives the latch.
interface sr_drive_ctrl_if;

    logic set_btn;
    logic clr_btn;
    logic S;
    logic R;
    logic EN;
    logic busy;
    logic conflict;
    logic dropped;

    modport master (
        output set_btn, clr_btn,
        input  S, R, EN, busy, conflict, dropped
    );

    modport slave (
        input  set_btn, clr_btn,
        output S, R, EN, busy, conflict, dropped
    );

endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, debounce counter and rising-edge press detector.
// The counter counts synchronized samples that disagree with the accepted level.
module btn_debounce #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db,
    output logic press
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic             db_d;
    logic [CNT_W-1:0] cnt;

    // NOTE: non-blocking assignments make every flop here sample the pre-edge
    // value, so s1 -> s2 -> db acts as a true pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            db   <= 1'b0;
            db_d <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= btn;
            s2   <= s1;
            db_d <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Only the accepted rising edge counts as a press, and releases are ignored.
    assign press = db & ~db_d;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Drives S/R/EN of a downstream SR latch from two debounced pushbuttons.
// Each operation runs setup, strobe and hold so S/R never move while EN is high.
module sr_drive_ctrl
    import sr_ctrl_pkg::*;
#(
    parameter int DB_CYCLES     = 4,
    parameter int STROBE_CYCLES = 1
) (
    input  logic           clk,
    input  logic           rst,
    sr_drive_ctrl_if.slave bus
);

    localparam int               CNT_W       = cnt_width(DB_CYCLES, STROBE_CYCLES);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);

    logic             set_db;
    logic             set_press;
    logic             clr_db;
    logic             clr_press;
    logic             any_press;

    state_t           state;
    logic [CNT_W-1:0] strobe_cnt;
    logic             s_q;
    logic             r_q;
    logic             en_q;
    logic             busy_q;
    logic             conflict_q;
    logic             dropped_q;

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_set_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.set_btn),
        .db    (set_db),
        .press (set_press)
    );

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (CNT_W)
    ) u_clr_debounce (
        .clk   (clk),
        .rst   (rst),
        .btn   (bus.clr_btn),
        .db    (clr_db),
        .press (clr_press)
    );

    assign any_press = set_press | clr_press;

    // S and R only change on IDLE->SETUP and HOLD->IDLE, both a cycle away from EN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            strobe_cnt <= '0;
            s_q        <= 1'b0;
            r_q        <= 1'b0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            conflict_q <= 1'b0;
            dropped_q  <= 1'b0;
        end else begin
            conflict_q <= 1'b0;
            dropped_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (set_press && clr_press) begin
                        conflict_q <= 1'b1;
                    end else if (any_press) begin
                        state  <= SETUP;
                        s_q    <= set_press;
                        r_q    <= clr_press;
                        en_q   <= 1'b0;
                        busy_q <= 1'b1;
                    end
                end
                SETUP: begin
                    dropped_q  <= any_press;
                    state      <= STROBE;
                    en_q       <= 1'b1;
                    strobe_cnt <= '0;
                end
                STROBE: begin
                    dropped_q <= any_press;
                    if (strobe_cnt == STROBE_LAST) begin
                        state <= HOLD;
                        en_q  <= 1'b0;
                    end else begin
                        strobe_cnt <= strobe_cnt + CNT_W'(1);
                    end
                end
                HOLD: begin
                    dropped_q <= any_press;
                    state     <= IDLE;
                    s_q       <= 1'b0;
                    r_q       <= 1'b0;
                    en_q      <= 1'b0;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    s_q    <= 1'b0;
                    r_q    <= 1'b0;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.S        = s_q;
    assign bus.R        = r_q;
    assign bus.EN       = en_q;
    assign bus.busy     = busy_q;
    assign bus.conflict = conflict_q;
    assign bus.dropped  = dropped_q;

    // Latch-safety properties; these are checked in simulation only.
    assert property (@(posedge clk) disable iff (rst) !(s_q && r_q));
    assert property (@(posedge clk) disable iff (rst) en_q |-> ($stable(s_q) && $stable(r_q)));
    assert property (@(posedge clk) disable iff (rst) set_press |-> set_db);
    assert property (@(posedge clk) disable iff (rst) clr_press |-> clr_db);

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Bench for sr_drive_ctrl: two instances (STROBE_CYCLES 1 and 3) on shared buttons,
// with latency tables, corner sequences and random buttons against a timeline model.
module tb_sr_drive_ctrl;

    localparam int DB   = 4;
    localparam int SC_A = 1;
    localparam int SC_B = 3;

    typedef struct {
        int set_in;
        int clr_in;
        int s;
        int r;
        int en;
        int busy;
        int conflict;
        int dropped;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_drive_ctrl_if if_a ();
    sr_drive_ctrl_if if_b ();

    sr_drive_ctrl #(.DB_CYCLES(DB), .STROBE_CYCLES(SC_A)) dut_a (.clk(clk), .rst(rst), .bus(if_a));
    sr_drive_ctrl #(.DB_CYCLES(DB), .STROBE_CYCLES(SC_B)) dut_b (.clk(clk), .rst(rst), .bus(if_b));

    logic [1:0] o_s, o_r, o_en, o_busy, o_conf, o_drop;
    assign o_s    = {if_b.S, if_a.S};
    assign o_r    = {if_b.R, if_a.R};
    assign o_en   = {if_b.EN, if_a.EN};
    assign o_busy = {if_b.busy, if_a.busy};
    assign o_conf = {if_b.conflict, if_a.conflict};
    assign o_drop = {if_b.dropped, if_a.dropped};

    int n_vec = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual != expected) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Timeline model: per button a 2-stage delay plus a window of the last DB
    // synchronized samples; per DUT the elapsed cycle count of the running op.
    int         m_t [2];
    int         m_dir_set [2];
    int         m_conf [2];
    int         m_drop [2];
    int         sc_of [2] = '{SC_A, SC_B};
    logic [1:0] m_s1, m_s2, m_db, m_press, m_new_db;
    logic [1:0] hist [$];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_t[d] = -1; m_dir_set[d] = 0; m_conf[d] = 0; m_drop[d] = 0;
        end
        m_s1 = '0; m_s2 = '0; m_db = '0; m_press = '0;
        hist.delete();
    endtask

    task automatic model_edge();
        bit all_diff;
        for (int d = 0; d < 2; d++) begin
            m_conf[d] = 0;
            m_drop[d] = 0;
            if (m_t[d] >= 0) begin
                if (m_press != 2'b00) m_drop[d] = 1;
                m_t[d]++;
                if (m_t[d] == sc_of[d] + 2) m_t[d] = -1;
            end else if (m_press == 2'b11) begin
                m_conf[d] = 1;
            end else if (m_press != 2'b00) begin
                m_t[d] = 0;
                m_dir_set[d] = int'(m_press[0]);
            end
        end
        hist.push_back(m_s2);
        if (hist.size() > DB) void'(hist.pop_front());
        m_new_db = m_db;
        if (hist.size() == DB) begin
            for (int b = 0; b < 2; b++) begin
                all_diff = 1'b1;
                foreach (hist[k]) if (hist[k][b] == m_db[b]) all_diff = 1'b0;
                if (all_diff) m_new_db[b] = ~m_db[b];
            end
        end
        m_press = m_new_db & ~m_db;
        m_db    = m_new_db;
        m_s2    = m_s1;
        m_s1    = {if_a.clr_btn, if_a.set_btn};
    endtask

    task automatic drive(input logic s, input logic c);
        if_a.set_btn = s; if_a.clr_btn = c;
        if_b.set_btn = s; if_b.clr_btn = c;
    endtask

    task automatic step(input logic s, input logic c);
        drive(s, c);
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Every cycle: compare both DUTs with the model and check the latch invariants.
    logic [1:0] p_s = '0, p_r = '0, p_en = '0;
    always @(negedge clk) begin
        if (rst) begin
            p_s <= '0; p_r <= '0; p_en <= '0;
        end else begin
            if (chk_en) begin
                for (int d = 0; d < 2; d++) begin
                    check($sformatf("model_S[%0d]", d), int'(o_s[d]), int'(m_t[d] >= 0 && m_dir_set[d] == 1));
                    check($sformatf("model_R[%0d]", d), int'(o_r[d]), int'(m_t[d] >= 0 && m_dir_set[d] == 0));
                    check($sformatf("model_EN[%0d]", d), int'(o_en[d]), int'(m_t[d] >= 1 && m_t[d] <= sc_of[d]));
                    check($sformatf("model_busy[%0d]", d), int'(o_busy[d]), int'(m_t[d] >= 0));
                    check($sformatf("model_conflict[%0d]", d), int'(o_conf[d]), m_conf[d]);
                    check($sformatf("model_dropped[%0d]", d), int'(o_drop[d]), m_drop[d]);
                    check($sformatf("inv_s_and_r[%0d]", d), int'(o_s[d] & o_r[d]), 0);
                    check($sformatf("inv_sr_stable_near_en[%0d]", d),
                          int'((o_en[d] | p_en[d]) & ((o_s[d] ^ p_s[d]) | (o_r[d] ^ p_r[d]))), 0);
                end
            end
            p_s <= o_s; p_r <= o_r; p_en <= o_en;
        end
    end

    task automatic check_vec(input string tag, input int i, input int d, input vec_t v);
        check($sformatf("%s[%0d].S", tag, i), int'(o_s[d]), v.s);
        check($sformatf("%s[%0d].R", tag, i), int'(o_r[d]), v.r);
        check($sformatf("%s[%0d].EN", tag, i), int'(o_en[d]), v.en);
        check($sformatf("%s[%0d].busy", tag, i), int'(o_busy[d]), v.busy);
        check($sformatf("%s[%0d].conflict", tag, i), int'(o_conf[d]), v.conflict);
        check($sformatf("%s[%0d].dropped", tag, i), int'(o_drop[d]), v.dropped);
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    vec_t  tab [3][13];
    string tab_name [3] = '{"clean_set", "conflict", "busy_drop"};
    int    tab_dut [3]  = '{0, 0, 1};
    int    bounce [6][2] = '{'{1, 3}, '{0, 2}, '{1, 2}, '{0, 2}, '{1, 5}, '{0, 16}};

    initial begin
        int   rises, rise_idx, idx, remaining;
        logic prev_busy, rs, rc;

        // Row i holds the inputs before edge i and the outputs expected after it.
        // clean_set on A (STROBE 1): S after edge 6, EN only after edge 7, idle after 9.
        for (int i = 0; i < 13; i++) tab[0][i] = '{1, 0, 0, 0, 0, 0, 0, 0};
        tab[0][6] = '{1, 0, 1, 0, 0, 1, 0, 0};
        tab[0][7] = '{1, 0, 1, 0, 1, 1, 0, 0};
        tab[0][8] = '{1, 0, 1, 0, 0, 1, 0, 0};
        // conflict on A: both buttons rise together; a single conflict pulse after edge 6.
        for (int i = 0; i < 13; i++) tab[1][i] = '{1, 1, 0, 0, 0, 0, 0, 0};
        tab[1][6] = '{1, 1, 0, 0, 0, 0, 1, 0};
        // busy_drop on B (STROBE 3): clr from edge 0, set from edge 2, detected in STROBE.
        tab[2][0]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        tab[2][1]  = '{0, 1, 0, 0, 0, 0, 0, 0};
        for (int i = 2; i < 6; i++) tab[2][i] = '{1, 1, 0, 0, 0, 0, 0, 0};
        tab[2][6]  = '{1, 1, 0, 1, 0, 1, 0, 0};
        tab[2][7]  = '{1, 1, 0, 1, 1, 1, 0, 0};
        tab[2][8]  = '{1, 1, 0, 1, 1, 1, 0, 1};
        tab[2][9]  = '{1, 1, 0, 1, 1, 1, 0, 0};
        tab[2][10] = '{1, 1, 0, 1, 0, 1, 0, 0};
        tab[2][11] = '{1, 1, 0, 0, 0, 0, 0, 0};
        tab[2][12] = '{1, 1, 0, 0, 0, 0, 0, 0};

        drive(1'b0, 1'b0);
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) check_vec("reset", 0, d, '{0, 0, 0, 0, 0, 0, 0, 0});
        rst = 1'b0;
        chk_en = 1'b1;
        idle_gap(3);

        for (int t = 0; t < 3; t++) begin
            for (int i = 0; i < 13; i++) begin
                step(1'(tab[t][i].set_in), 1'(tab[t][i].clr_in));
                check_vec(tab_name[t], i, tab_dut[t], tab[t][i]);
            end
            idle_gap(16);
        end

        // Bounce: set pulses of 3 and 2 cycles are rejected, the 5-cycle level gives one press.
        rises = 0; rise_idx = -1; idx = 0; prev_busy = 1'b0;
        for (int p = 0; p < 6; p++) begin
            for (int k = 0; k < bounce[p][1]; k++) begin
                step(1'(bounce[p][0]), 1'b0);
                if (o_busy[0] && !prev_busy) begin
                    rises++;
                    if (rises == 1) rise_idx = idx;
                end
                prev_busy = o_busy[0];
                idx++;
            end
        end
        check("bounce_press_count", rises, 1);
        check("bounce_press_edge", rise_idx, 9 + DB + 2);

        // Reset mid-STROBE on B with clr held through reset.
        for (int i = 0; i < 9; i++) step(1'b0, 1'b1);
        check("pre_reset_b_EN", int'(o_en[1]), 1);
        rst = 1'b1;
        model_reset();
        #1;
        for (int d = 0; d < 2; d++) check_vec("async_reset", 0, d, '{0, 1, 0, 0, 0, 0, 0, 0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("post_reset_b_busy", int'(o_busy[1]), 0);
        rises = 0; rise_idx = -1; prev_busy = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1);
            if (o_busy[1] && !prev_busy) begin
                rises++;
                if (rises == 1) rise_idx = i;
                check("held_through_reset_R", int'(o_r[1]), 1);
            end
            prev_busy = o_busy[1];
        end
        check("held_through_reset_press_count", rises, 1);
        check("held_through_reset_press_edge", rise_idx, 2 + DB);
        idle_gap(16);

        // Random button levels held for random durations.
        remaining = 0;
        rs = 1'b0;
        rc = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (remaining == 0) begin
                rs = 1'($urandom_range(0, 1));
                rc = ($urandom_range(0, 3) == 0);
                remaining = int'($urandom_range(1, 14));
            end
            remaining--;
            step(rs, rc);
        end
        idle_gap(16);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
